fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register that feeds the decode-stage controller.
- Holds the PC, drives the instruction-memory address, and latches the fetched word into the IF/ID register.
- Splits the decode-stage instruction into op/funct3/funct7 for the controller.
- Accepts stall, flush, branch-redirect and pause (halt) requests from decode/hazard logic; keeps a fetch counter.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem address, IF/ID register and halt control.
// Feeds decode with the latched instruction and its op/funct fields.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            brtaken,
  input  logic [XLEN-1:0] brtarget,
  input  logic            pause,
  output logic [XLEN-1:0] pc_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d,
  output logic [6:0]      op_d,
  output logic [2:0]      funct3_d,
  output logic [6:0]      funct7_d,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  if_id_t          ifid_q, ifid_n;
  logic [31:0]     cnt_q, cnt_n;
  logic [XLEN-1:0] pcplus4_f;

  assign pcplus4_f = pc_q + FOUR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP_INSTR, pc: '0,
                   pcplus4: '0, valid: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_n;
      cnt_q   <= cnt_n;
    end
  end

  // Bubbles keep pc_d/pcplus4_d so decode still sees the last real PC.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ifid_n  = ifid_q;
    cnt_n   = cnt_q;
    if (state_q == RUN) begin
      priority case (1'b1)
        stall_d: ;
        (pause && ifid_q.valid): begin
          state_n      = HALTED;
          ifid_n.instr = NOP_INSTR;
          ifid_n.valid = 1'b0;
        end
        brtaken: begin
          pc_n         = {brtarget[XLEN-1:2], 2'b00};
          ifid_n.instr = NOP_INSTR;
          ifid_n.valid = 1'b0;
        end
        flush_d: begin
          pc_n         = pcplus4_f;
          ifid_n.instr = NOP_INSTR;
          ifid_n.valid = 1'b0;
        end
        default: begin
          pc_n           = pcplus4_f;
          ifid_n.instr   = imem_rdata;
          ifid_n.pc      = pc_q;
          ifid_n.pcplus4 = pcplus4_f;
          ifid_n.valid   = 1'b1;
          cnt_n          = cnt_q + 32'd1;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign pc_f        = pc_q;
  assign instr_d     = ifid_q.instr;
  assign pc_d        = ifid_q.pc;
  assign pcplus4_d   = ifid_q.pcplus4;
  assign valid_d     = ifid_q.valid;
  assign op_d        = ifid_q.instr[6:0];
  assign funct3_d    = ifid_q.instr[14:12];
  assign funct7_d    = ifid_q.instr[31:25];
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall_d, flush_d, brtaken, pause;
  logic [31:0] brtarget;
  logic [31:0] pc_f, instr_d, pc_d, pcplus4_d;
  logic        valid_d, halted;
  logic [6:0]  op_d, funct7_d;
  logic [2:0]  funct3_d;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:  imem = 32'h00500093;
      32'h4:  imem = 32'h00600113;
      32'h8:  imem = 32'h002081B3;
      32'hC:  imem = 32'h00000013;
      32'h40: imem = 32'h4020D1B3;
      default: imem = {16'hABCD, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = imem(imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .flush_d(flush_d),
    .brtaken(brtaken), .brtarget(brtarget),
    .pause(pause), .pc_f(pc_f),
    .instr_d(instr_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .op_d(op_d), .funct3_d(funct3_d),
    .funct7_d(funct7_d), .halted(halted),
    .fetch_count(fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    brtaken  = 1'b0;
    brtarget = '0;
    pause    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    n_checks++;
    if (pc_f !== 32'h0 || instr_d !== NOP || valid_d !== 1'b0
        || pc_d !== 32'h0 || pcplus4_d !== 32'h0
        || halted !== 1'b0 || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: pc_f=%h instr=%h v=%b pc_d=%h p4=%h h=%b cnt=%0d",
               pc_f, instr_d, valid_d, pc_d, pcplus4_d, halted, fetch_count);
    end
    n_checks++;
    if (imem_addr !== pc_f) begin
      n_fail++;
      $display("FAIL imem_addr: got %h want %h", imem_addr, pc_f);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      step();
      n_checks++;
      if (pc_f !== a + 4 || instr_d !== imem(a) || pc_d !== a
          || pcplus4_d !== a + 4 || valid_d !== 1'b1
          || fetch_count !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL run%0d: pc_f=%h instr=%h pc_d=%h p4=%h v=%b cnt=%0d",
                 i, pc_f, instr_d, pc_d, pcplus4_d, valid_d, fetch_count);
      end
    end
  endtask

  task automatic test_stall();
    test_reset();
    step();
    step();
    stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (pc_f !== 32'h8 || instr_d !== imem(32'h4) || pc_d !== 32'h4
          || fetch_count !== 32'd2) begin
        n_fail++;
        $display("FAIL stall%0d: pc_f=%h instr=%h pc_d=%h cnt=%0d",
                 i, pc_f, instr_d, pc_d, fetch_count);
      end
    end
    stall_d = 1'b0;
    step();
    n_checks++;
    if (pc_f !== 32'hC || instr_d !== 32'h002081B3 || pc_d !== 32'h8
        || op_d !== 7'h33 || funct3_d !== 3'd0 || funct7_d !== 7'h00
        || fetch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL resume: pc_f=%h instr=%h pc_d=%h op=%h cnt=%0d",
               pc_f, instr_d, pc_d, op_d, fetch_count);
    end
  endtask

  task automatic test_branch();
    brtaken  = 1'b1;
    brtarget = 32'h40;
    step();
    n_checks++;
    if (pc_f !== 32'h40 || instr_d !== NOP || valid_d !== 1'b0
        || pc_d !== 32'h8 || fetch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL branch: pc_f=%h instr=%h v=%b pc_d=%h cnt=%0d",
               pc_f, instr_d, valid_d, pc_d, fetch_count);
    end
    idle_inputs();
    step();
    n_checks++;
    if (instr_d !== 32'h4020D1B3 || pc_d !== 32'h40 || valid_d !== 1'b1
        || pcplus4_d !== 32'h44 || pc_f !== 32'h44) begin
      n_fail++;
      $display("FAIL target: instr=%h pc_d=%h v=%b p4=%h pc_f=%h",
               instr_d, pc_d, valid_d, pcplus4_d, pc_f);
    end
    n_checks++;
    if (op_d !== 7'h33 || funct3_d !== 3'd5 || funct7_d !== 7'h20) begin
      n_fail++;
      $display("FAIL fields: op=%h f3=%h f7=%h want 33 5 20",
               op_d, funct3_d, funct7_d);
    end
  endtask

  task automatic test_branch_stall();
    brtaken  = 1'b1;
    brtarget = 32'h80;
    stall_d  = 1'b1;
    step();
    n_checks++;
    if (pc_f !== 32'h44 || instr_d !== 32'h4020D1B3 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL br_stall: pc_f=%h instr=%h v=%b", pc_f, instr_d, valid_d);
    end
    stall_d = 1'b0;
    step();
    n_checks++;
    if (pc_f !== 32'h80 || valid_d !== 1'b0) begin
      n_fail++;
      $display("FAIL br_after: pc_f=%h v=%b want 80 0", pc_f, valid_d);
    end
    brtarget = 32'h43;
    step();
    n_checks++;
    if (pc_f !== 32'h40) begin
      n_fail++;
      $display("FAIL misalign: pc_f=%h want 40", pc_f);
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    logic [31:0] cnt;
    step();
    pause = 1'b1;
    step();
    cnt = fetch_count;
    n_checks++;
    if (halted !== 1'b1 || valid_d !== 1'b0 || pc_f !== 32'h44
        || instr_d !== NOP || pc_d !== 32'h40) begin
      n_fail++;
      $display("FAIL halt: h=%b v=%b pc_f=%h instr=%h pc_d=%h",
               halted, valid_d, pc_f, instr_d, pc_d);
    end
    pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      brtaken  = i[0];
      flush_d  = ~i[0];
      brtarget = 32'h100;
      step();
    end
    n_checks++;
    if (halted !== 1'b1 || valid_d !== 1'b0 || pc_f !== 32'h44
        || fetch_count !== cnt) begin
      n_fail++;
      $display("FAIL halt_hold: h=%b v=%b pc_f=%h cnt=%0d want %0d",
               halted, valid_d, pc_f, fetch_count, cnt);
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (pc_f !== 32'h0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_reset: pc_f=%h h=%b cnt=%0d",
               pc_f, halted, fetch_count);
    end
    step();
    reset = 1'b0;
    pause = 1'b1;
    step();
    n_checks++;
    if (halted !== 1'b0 || pc_f !== 32'h4 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_bubble: h=%b pc_f=%h v=%b want 0 4 1",
               halted, pc_f, valid_d);
    end
    pause = 1'b0;
  endtask

  task automatic test_wrap();
    brtaken  = 1'b1;
    brtarget = 32'hFFFFFFFC;
    step();
    idle_inputs();
    step();
    n_checks++;
    if (pc_f !== 32'h0 || pcplus4_d !== 32'h0 || pc_d !== 32'hFFFFFFFC
        || instr_d !== imem(32'hFFFFFFFC) || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc_f=%h p4=%h pc_d=%h instr=%h v=%b",
               pc_f, pcplus4_d, pc_d, instr_d, valid_d);
    end
    flush_d = 1'b1;
    step();
    n_checks++;
    if (valid_d !== 1'b0 || pc_f !== 32'h4 || instr_d !== NOP
        || pc_d !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL flush: v=%b pc_f=%h instr=%h pc_d=%h",
               valid_d, pc_f, instr_d, pc_d);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_halt();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
